sent_tx_msg_sched: RTL and testbench

SENT_TX_MSG_SCHED -- requirements
Module: sent_tx_msg_sched

---
 rtl/sent_pkg.sv | 40 ++++
 rtl/sent_rr_arbiter.sv | 37 +++
 rtl/sent_tx_msg_sched.sv | 206 ++++++++++++++++++++
 tb/tb_sent_tx_msg_sched.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_pkg.sv
// Shared types for the SENT transmit message scheduler: scheduler state
// encoding, requester count and the latched message payload.
package sent_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_BUSY   = 3'd3,
        ST_GAP    = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
        logic        fmt;
        logic        cfg;
    } payload_t;

    localparam payload_t PAYLOAD_ZERO = '{id: 8'h00, data: 16'h0000, fmt: 1'b0, cfg: 1'b0};

    // Extract requester idx's message fields from the packed request buses.
    function automatic payload_t pick_payload(
        input logic [8*N_REQ-1:0]  ids,
        input logic [16*N_REQ-1:0] data,
        input logic [N_REQ-1:0]    fmt,
        input logic [N_REQ-1:0]    cfg,
        input logic [1:0]          idx
    );
        payload_t p;
        p.id   = ids[{idx, 3'b000} +: 8];
        p.data = data[{idx, 4'b0000} +: 16];
        p.fmt  = fmt[idx];
        p.cfg  = cfg[idx];
        return p;
    endfunction

endpackage

// File: rtl/sent_rr_arbiter.sv
// Combinational 4-way round-robin pick: the search starts one past the last
// winner and wraps, so every active requester is reached within four picks.
module sent_rr_arbiter
    import sent_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_winner,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [1:0]       grant_idx,
    output logic             grant_valid
);

    logic [1:0] start_s;
    logic [3:0] rot_s;
    logic [1:0] offset_s;

    // Rotate requests so bit 0 is the first candidate, then priority-encode.
    always_comb begin
        start_s = last_winner + 2'd1;
        rot_s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rot_s[i] = req[start_s + 2'(i)];
        end
        offset_s    = 2'd0;
        grant_valid = 1'b0;
        casez (rot_s)
            4'b???1: begin offset_s = 2'd0; grant_valid = 1'b1; end
            4'b??10: begin offset_s = 2'd1; grant_valid = 1'b1; end
            4'b?100: begin offset_s = 2'd2; grant_valid = 1'b1; end
            4'b1000: begin offset_s = 2'd3; grant_valid = 1'b1; end
            default: begin offset_s = 2'd0; grant_valid = 1'b0; end
        endcase
        grant_idx    = start_s + offset_s;
        grant_onehot = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
    end

endmodule

// File: rtl/sent_tx_msg_sched.sv
// SENT slow-channel message scheduler: arbitrates four requesters round-robin,
// latches the winner's payload, launches the TX frame controller and waits for
// its completion edge before a fixed inter-message gap.
// Optional build macro SENT_SCHED_TIMEOUT_EN adds a BUSY watchdog that aborts
// a message after TIMEOUT_CYCLES cycles without completion.
module sent_tx_msg_sched #(
    parameter int N_REQ          = sent_pkg::N_REQ,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk_tx,
    input  logic                  reset_tx,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_id,
    input  logic [16*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_fmt,
    input  logic [N_REQ-1:0]      req_cfg,
    input  logic                  tx_idle,
    output logic                  enable,
    output logic [7:0]            id,
    output logic [15:0]           data_bit_field,
    output logic                  channel_format,
    output logic                  config_bit,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      ack,
    output logic                  busy,
    output logic                  err_timeout
);

    import sent_pkg::*;

    if (N_REQ != 4) begin : g_bad_n_req
        $error("sent_tx_msg_sched supports exactly four requesters");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777216) begin : g_bad_timeout
        $error("sent_tx_msg_sched TIMEOUT_CYCLES must fit the 24-bit watchdog");
    end

    // Last GAP counter value; a zero gap still spends one cycle in GAP.
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_e        state_r, state_nxt_s;
    payload_t            payload_r, payload_nxt_s;
    logic [N_REQ-1:0]    grant_r, grant_nxt_s;
    logic [N_REQ-1:0]    ack_r, ack_nxt_s;
    logic [1:0]          winner_r, winner_nxt_s;
    logic [1:0]          last_winner_r, last_winner_nxt_s;
    logic [15:0]         gap_cnt_r, gap_cnt_nxt_s;
    logic                enable_r, enable_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                err_r, err_nxt_s;
    logic                tx_idle_prev_r;
    logic                completion_s;
    logic                timeout_hit_s;
    logic [N_REQ-1:0]    arb_onehot_s;
    logic [1:0]          arb_idx_s;
    logic                arb_valid_s;

    sent_rr_arbiter u_arb (
        .req          (req),
        .last_winner  (last_winner_r),
        .grant_onehot (arb_onehot_s),
        .grant_idx    (arb_idx_s),
        .grant_valid  (arb_valid_s)
    );

    // A level already high when BUSY starts is not a completion: the prior
    // value is sampled through LAUNCH, so only a genuine 0->1 step counts.
    assign completion_s = tx_idle & ~tx_idle_prev_r;

`ifdef SENT_SCHED_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] tmo_cnt_r;

    // Watchdog: counts BUSY cycles, cleared in every other state.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            tmo_cnt_r <= 24'd0;
        end else if (state_r == ST_BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + 24'd1;
        end else begin
            tmo_cnt_r <= 24'd0;
        end
    end

    assign timeout_hit_s = (state_r == ST_BUSY) && (tmo_cnt_r == TMO_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Previous tx_idle level for edge detection.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            tx_idle_prev_r <= 1'b0;
        end else begin
            tx_idle_prev_r <= tx_idle;
        end
    end

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        state_nxt_s       = state_r;
        payload_nxt_s     = payload_r;
        grant_nxt_s       = grant_r;
        winner_nxt_s      = winner_r;
        last_winner_nxt_s = last_winner_r;
        gap_cnt_nxt_s     = gap_cnt_r;
        enable_nxt_s      = 1'b0;
        ack_nxt_s         = {N_REQ{1'b0}};
        err_nxt_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (arb_valid_s) begin
                    state_nxt_s   = ST_LAUNCH;
                    payload_nxt_s = pick_payload(req_id, req_data, req_fmt, req_cfg, arb_idx_s);
                    grant_nxt_s   = arb_onehot_s;
                    winner_nxt_s  = arb_idx_s;
                    enable_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {N_REQ{1'b0}};
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_BUSY;
            end
            ST_BUSY: begin
                // Completion has priority over a coincident watchdog expiry.
                if (completion_s) begin
                    state_nxt_s       = ST_GAP;
                    ack_nxt_s         = grant_r;
                    grant_nxt_s       = {N_REQ{1'b0}};
                    last_winner_nxt_s = winner_r;
                    gap_cnt_nxt_s     = 16'd0;
                end else if (timeout_hit_s) begin
                    state_nxt_s       = ST_GAP;
                    err_nxt_s         = 1'b1;
                    grant_nxt_s       = {N_REQ{1'b0}};
                    last_winner_nxt_s = winner_r;
                    gap_cnt_nxt_s     = 16'd0;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r >= GAP_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    gap_cnt_nxt_s = 16'd0;
                end else begin
                    state_nxt_s   = ST_GAP;
                    gap_cnt_nxt_s = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {N_REQ{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_r       <= ST_IDLE;
            payload_r     <= PAYLOAD_ZERO;
            grant_r       <= {N_REQ{1'b0}};
            ack_r         <= {N_REQ{1'b0}};
            winner_r      <= 2'd0;
            last_winner_r <= 2'd3;
            gap_cnt_r     <= 16'd0;
            enable_r      <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            payload_r     <= payload_nxt_s;
            grant_r       <= grant_nxt_s;
            ack_r         <= ack_nxt_s;
            winner_r      <= winner_nxt_s;
            last_winner_r <= last_winner_nxt_s;
            gap_cnt_r     <= gap_cnt_nxt_s;
            enable_r      <= enable_nxt_s;
            busy_r        <= busy_nxt_s;
            err_r         <= err_nxt_s;
        end
    end

    assign enable         = enable_r;
    assign id             = payload_r.id;
    assign data_bit_field = payload_r.data;
    assign channel_format = payload_r.fmt;
    assign config_bit     = payload_r.cfg;
    assign grant          = grant_r;
    assign ack            = ack_r;
    assign busy           = busy_r;
    assign err_timeout    = err_r;

endmodule

// File: tb/tb_sent_tx_msg_sched.sv
// Self-checking bench for sent_tx_msg_sched: randomized requests and payloads
// checked against a round-robin reference model kept in the bench.
`timescale 1ns/1ps
module tb_sent_tx_msg_sched;

    localparam int GAP = 2;
    localparam int TMO = 64;
    localparam int GAP_TO_EN = ((GAP > 0) ? GAP : 1) + 2;

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic [3:0]  req;
    logic [31:0] req_id;
    logic [63:0] req_data;
    logic [3:0]  req_fmt;
    logic [3:0]  req_cfg;
    logic        tx_idle;
    logic        enable;
    logic [7:0]  id;
    logic [15:0] data_bit_field;
    logic        channel_format;
    logic        config_bit;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic        err_timeout;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  t_id   [4];
    logic [15:0] t_data [4];
    logic        t_fmt  [4];
    logic        t_cfg  [4];
    int          m_last;

    always #5 clk_tx = ~clk_tx;

    sent_tx_msg_sched #(
        .N_REQ          (4),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_tx         (clk_tx),
        .reset_tx       (reset_tx),
        .req            (req),
        .req_id         (req_id),
        .req_data       (req_data),
        .req_fmt        (req_fmt),
        .req_cfg        (req_cfg),
        .tx_idle        (tx_idle),
        .enable         (enable),
        .id             (id),
        .data_bit_field (data_bit_field),
        .channel_format (channel_format),
        .config_bit     (config_bit),
        .grant          (grant),
        .ack            (ack),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    task automatic step();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic drive_payload();
        for (int k = 0; k < 4; k++) begin
            req_id[8*k +: 8]    = t_id[k];
            req_data[16*k +: 16] = t_data[k];
            req_fmt[k]          = t_fmt[k];
            req_cfg[k]          = t_cfg[k];
        end
    endtask

    task automatic random_payload();
        for (int k = 0; k < 4; k++) begin
            t_id[k]   = 8'($urandom);
            t_data[k] = 16'($urandom);
            t_fmt[k]  = 1'($urandom);
            t_cfg[k]  = 1'($urandom);
        end
        drive_payload();
    endtask

    // Reference round-robin: first active requester after the last winner.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        reset_tx = 1'b1;
        req = 4'b0000;
        tx_idle = 1'b0;
        step();
        step();
        reset_tx = 1'b0;
        step();
        m_last = 3;
    endtask

    task automatic test_reset();
        reset_tx = 1'b1;
        req = 4'b1111;
        tx_idle = 1'b0;
        random_payload();
        step();
        step();
        vectors++;
        if ({enable, grant, ack, busy, err_timeout, id, data_bit_field, channel_format, config_bit} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b gnt=%b ack=%b busy=%b err=%b id=%h data=%h fmt=%b cfg=%b, expected all 0",
                     enable, grant, ack, busy, err_timeout, id, data_bit_field, channel_format, config_bit);
        end
        req = 4'b0000;
        reset_tx = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
        m_last = 3;
    endtask

    task automatic test_single();
        int w;
        logic [3:0] eg;
        random_payload();
        tx_idle = 1'b0;
        req = 4'b0001;
        w = rr_pick(req, m_last);
        eg = 4'b0001 << w;
        step();
        vectors++;
        if (enable !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL single_arb: got en=%b busy=%b expected en=0 busy=1", enable, busy);
        end
        step();
        vectors++;
        if (enable !== 1'b1 || grant !== eg) begin
            miscompares++; $display("FAIL single_launch: got en=%b gnt=%b expected en=1 gnt=%b", enable, grant, eg);
        end
        vectors++;
        if ({id, data_bit_field, channel_format, config_bit} !== {t_id[w], t_data[w], t_fmt[w], t_cfg[w]}) begin
            miscompares++; $display("FAIL single_payload: got %h/%h/%b/%b expected %h/%h/%b/%b",
                id, data_bit_field, channel_format, config_bit, t_id[w], t_data[w], t_fmt[w], t_cfg[w]);
        end
        step();
        vectors++;
        if (enable !== 1'b0) begin miscompares++; $display("FAIL single_enable_pulse: got %b expected 0", enable); end
        for (int k = 0; k < 98; k++) begin
            step();
            vectors++;
            if (ack !== 4'b0000 || grant !== eg || busy !== 1'b1) begin
                miscompares++; $display("FAIL single_busy_hold: cycle %0d ack=%b gnt=%b busy=%b expected ack=0000 gnt=%b busy=1", k, ack, grant, busy, eg);
            end
        end
        tx_idle = 1'b1;
        step();
        vectors++;
        if (ack !== eg || grant !== 4'b0000 || busy !== 1'b1) begin
            miscompares++; $display("FAIL single_ack: got ack=%b gnt=%b busy=%b expected ack=%b gnt=0000 busy=1", ack, grant, busy, eg);
        end
        m_last = w;
        req = 4'b0000;
        step();
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b1) begin
            miscompares++; $display("FAIL single_gap: got ack=%b busy=%b expected ack=0000 busy=1", ack, busy);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
        tx_idle = 1'b0;
        step();
    endtask

    task automatic test_arb_abandon();
        req = 4'b0010;
        step();
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (enable !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
                miscompares++; $display("FAIL abandon: cycle %0d en=%b gnt=%b busy=%b expected 0/0000/0", k, enable, grant, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        int w, n, exp_n;
        logic [3:0] eg;
        apply_reset();
        random_payload();
        req = 4'b1111;
        exp_n = 2;
        for (int m = 0; m < 5; m++) begin
            n = 0;
            while (enable !== 1'b1 && n < 12) begin step(); n++; end
            vectors++;
            if (enable !== 1'b1 || n != exp_n) begin
                miscompares++; $display("FAIL rr_launch_latency: msg %0d en=%b after %0d cycles, expected en=1 after %0d", m, enable, n, exp_n);
            end
            w = rr_pick(req, m_last);
            eg = 4'b0001 << w;
            vectors++;
            if (grant !== eg || {id, data_bit_field, channel_format, config_bit} !== {t_id[w], t_data[w], t_fmt[w], t_cfg[w]}) begin
                miscompares++; $display("FAIL rr_grant: msg %0d gnt=%b id=%h data=%h expected gnt=%b id=%h data=%h", m, grant, id, data_bit_field, eg, t_id[w], t_data[w]);
            end
            repeat ($urandom_range(1, 20)) step();
            tx_idle = 1'b1;
            step();
            vectors++;
            if (ack !== eg || grant !== 4'b0000) begin
                miscompares++; $display("FAIL rr_ack: msg %0d ack=%b gnt=%b expected ack=%b gnt=0000", m, ack, grant, eg);
            end
            m_last = w;
            tx_idle = 1'b0;
            random_payload();
            exp_n = GAP_TO_EN;
        end
        req = 4'b0000;
        repeat (6) step();
    endtask

    task automatic test_payload_hold();
        int n;
        apply_reset();
        random_payload();
        t_id[2] = 8'h5A; t_data[2] = 16'h0C3F; t_fmt[2] = 1'b1; t_cfg[2] = 1'b1;
        drive_payload();
        req = 4'b0100;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
        vectors++;
        if (grant !== 4'b0100 || id !== 8'h5A || data_bit_field !== 16'h0C3F || channel_format !== 1'b1 || config_bit !== 1'b1) begin
            miscompares++; $display("FAIL hold_latch: gnt=%b id=%h data=%h fmt=%b cfg=%b expected 0100/5a/0c3f/1/1", grant, id, data_bit_field, channel_format, config_bit);
        end
        for (int k = 0; k < 10; k++) begin
            req_data = {$urandom, $urandom};
            req_id = $urandom;
            req = 4'b0100 | 4'($urandom);
            step();
            vectors++;
            if (grant !== 4'b0100 || id !== 8'h5A || data_bit_field !== 16'h0C3F || channel_format !== 1'b1 || config_bit !== 1'b1) begin
                miscompares++; $display("FAIL hold_busy: cycle %0d gnt=%b id=%h data=%h expected 0100/5a/0c3f", k, grant, id, data_bit_field);
            end
        end
        tx_idle = 1'b1;
        step();
        req = 4'b0000;
        vectors++;
        if (ack !== 4'b0100 || id !== 8'h5A || data_bit_field !== 16'h0C3F) begin
            miscompares++; $display("FAIL hold_ack: ack=%b id=%h data=%h expected 0100/5a/0c3f", ack, id, data_bit_field);
        end
        m_last = 2;
        tx_idle = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_level_high();
        int w, n;
        logic [3:0] eg;
        random_payload();
        req = 4'b0001;
        tx_idle = 1'b1;
        w = rr_pick(req, m_last);
        eg = 4'b0001 << w;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
        vectors++;
        if (enable !== 1'b1 || grant !== eg) begin miscompares++; $display("FAIL level_launch: en=%b gnt=%b expected 1/%b", enable, grant, eg); end
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (ack !== 4'b0000 || grant !== eg) begin miscompares++; $display("FAIL level_high_no_ack: cycle %0d ack=%b gnt=%b expected 0000/%b", k, ack, grant, eg); end
        end
        tx_idle = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (ack !== 4'b0000) begin miscompares++; $display("FAIL level_low_no_ack: cycle %0d ack=%b expected 0000", k, ack); end
        end
        tx_idle = 1'b1;
        step();
        vectors++;
        if (ack !== eg) begin miscompares++; $display("FAIL level_rise_ack: ack=%b expected %b", ack, eg); end
        m_last = w;
        req = 4'b0000;
        tx_idle = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_timeout();
        int w, n;
        logic [3:0] eg;
        apply_reset();
        random_payload();
        req = 4'b0011;
        w = rr_pick(req, m_last);
        eg = 4'b0001 << w;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
`ifdef SENT_SCHED_TIMEOUT_EN
        for (int j = 1; j <= TMO; j++) begin
            step();
            vectors++;
            if (err_timeout !== 1'b0 || ack !== 4'b0000 || grant !== eg) begin
                miscompares++; $display("FAIL tmo_early: cycle %0d err=%b ack=%b gnt=%b expected 0/0000/%b", j, err_timeout, ack, grant, eg);
            end
        end
        step();
        vectors++;
        if (err_timeout !== 1'b1 || ack !== 4'b0000 || grant !== 4'b0000) begin
            miscompares++; $display("FAIL tmo_abort: err=%b ack=%b gnt=%b expected 1/0000/0000", err_timeout, ack, grant);
        end
        step();
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse: err=%b expected 0", err_timeout); end
`else
        for (int j = 1; j <= 3 * TMO; j++) begin
            step();
            vectors++;
            if (busy !== 1'b1 || err_timeout !== 1'b0 || ack !== 4'b0000 || grant !== eg) begin
                miscompares++; $display("FAIL tmo_disabled_wait: cycle %0d busy=%b err=%b ack=%b gnt=%b expected 1/0/0000/%b", j, busy, err_timeout, ack, grant, eg);
            end
        end
        tx_idle = 1'b1;
        step();
        vectors++;
        if (ack !== eg) begin miscompares++; $display("FAIL tmo_disabled_ack: ack=%b expected %b", ack, eg); end
        tx_idle = 1'b0;
`endif
        m_last = w;
        w = rr_pick(req, m_last);
        eg = 4'b0001 << w;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
        vectors++;
        if (enable !== 1'b1 || grant !== eg) begin miscompares++; $display("FAIL tmo_next_winner: en=%b gnt=%b expected 1/%b", enable, grant, eg); end
        step();
        tx_idle = 1'b1;
        step();
        vectors++;
        if (ack !== eg) begin miscompares++; $display("FAIL tmo_next_ack: ack=%b expected %b", ack, eg); end
        m_last = w;
        req = 4'b0000;
        tx_idle = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset_busy();
        int w, n;
        logic [3:0] eg;
        random_payload();
        req = 4'b0100;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
        repeat (4) step();
        reset_tx = 1'b1;
        step();
        vectors++;
        if ({enable, grant, ack, busy, err_timeout, id, data_bit_field, channel_format, config_bit} !== 37'd0) begin
            miscompares++; $display("FAIL rstbusy_outputs: en=%b gnt=%b ack=%b busy=%b id=%h data=%h expected all 0", enable, grant, ack, busy, id, data_bit_field);
        end
        reset_tx = 1'b0;
        m_last = 3;
        req = 4'b1001;
        w = rr_pick(req, m_last);
        eg = 4'b0001 << w;
        n = 0;
        while (enable !== 1'b1 && n < 12) begin step(); n++; end
        vectors++;
        if (enable !== 1'b1 || grant !== eg) begin miscompares++; $display("FAIL rstbusy_regrant: en=%b gnt=%b expected 1/%b", enable, grant, eg); end
        step();
        tx_idle = 1'b1;
        step();
        vectors++;
        if (ack !== eg) begin miscompares++; $display("FAIL rstbusy_ack: ack=%b expected %b", ack, eg); end
        m_last = w;
        req = 4'b0000;
        tx_idle = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_random();
        int w, n, exp_n;
        logic [3:0] eg;
        apply_reset();
        random_payload();
        req = 4'($urandom_range(1, 15));
        exp_n = 2;
        for (int m = 0; m < 30; m++) begin
            w = rr_pick(req, m_last);
            eg = 4'b0001 << w;
            n = 0;
            while (enable !== 1'b1 && n < 12) begin step(); n++; end
            vectors++;
            if (enable !== 1'b1 || n != exp_n || grant !== eg) begin
                miscompares++; $display("FAIL rand_launch: msg %0d en=%b n=%0d gnt=%b expected en=1 n=%0d gnt=%b", m, enable, n, grant, exp_n, eg);
            end
            vectors++;
            if ({id, data_bit_field, channel_format, config_bit} !== {t_id[w], t_data[w], t_fmt[w], t_cfg[w]}) begin
                miscompares++; $display("FAIL rand_payload: msg %0d got %h/%h/%b/%b expected %h/%h/%b/%b", m,
                    id, data_bit_field, channel_format, config_bit, t_id[w], t_data[w], t_fmt[w], t_cfg[w]);
            end
            repeat ($urandom_range(1, 12)) step();
            tx_idle = 1'b1;
            step();
            vectors++;
            if (ack !== eg || grant !== 4'b0000) begin
                miscompares++; $display("FAIL rand_ack: msg %0d ack=%b gnt=%b expected %b/0000", m, ack, grant, eg);
            end
            m_last = w;
            tx_idle = 1'b0;
            random_payload();
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                repeat (GAP_TO_EN) step();
                vectors++;
                if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_idle: msg %0d busy=%b expected 0", m, busy); end
                exp_n = 2;
            end else begin
                exp_n = GAP_TO_EN;
            end
            req = 4'($urandom_range(1, 15));
        end
        req = 4'b0000;
        repeat (6) step();
    endtask

    initial begin
        reset_tx = 1'b1;
        req = 4'b0000;
        req_id = 32'd0;
        req_data = 64'd0;
        req_fmt = 4'b0000;
        req_cfg = 4'b0000;
        tx_idle = 1'b0;
        m_last = 3;
        test_reset();
        test_single();
        test_arb_abandon();
        test_round_robin();
        test_payload_hold();
        test_level_high();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
